word_memory_sequencer: RTL and testbench
========================================

# word_memory_sequencer

Parametrised multi-byte memory transfer engine for the byte-wide Memory of the datapath. It replaces the manual per-byte load and store sequences, where the control unit stepped the address register and MuxC/DR byte lanes one cycle at a time. A single Start moves 1..WORD_BYTES bytes at consecutive addresses between a WORD_BYTES-wide word and memory. It supports little- or big-endian lane order, optional sign extension on loads, and returns the post-transfer address for the address register file.

## Interface
- WORD_BYTES, 4, word size in bytes; legal values 2, 4, 8.
- ADDR_W, 16, memory address width.
- BIG_ENDIAN, 0, lane order: 0 = little-endian, 1 = big-endian.
- Derived: LEN_W = $clog2(WORD_BYTES); DW = 8*WORD_BYTES.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  request a transfer; sampled only when the block can accept.
- Op  in  1  0 = load (memory→RData), 1 = store (WData→memory).
- Len  in  LEN_W  number of bytes minus 1.
- Addr  in  ADDR_W  base address.
- WData  in  DW  store word; only lanes 0..Len are used.
- SignExt  in  1  load only: sign-fill the upper lanes.
- Mem_Address  out  ADDR_W  memory address.
- Mem_Data  out  8  memory write byte.
- Mem_WR  out  1  1 = write, 0 = read.
- Mem_CS  out  1  active-low memory chip select.
- MemOut  in  8  memory read byte; combinational, valid in the same cycle as Mem_Address.
- Busy  out  1  high in XFER.
- Done  out  1  one-cycle completion pulse.
- RData  out  DW  load result; holds its value until the next load completes.
- NextAddr  out  ADDR_W  Addr+Len+1, modulo 2^ADDR_W; valid from Done onward.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE:
  - If Start=1, latch Op, Len, Addr, WData, SignExt; clear the index to 0; go to XFER.
- XFER, byte index i = 0..Len, one byte per cycle:
  - Mem_CS=0.
  - Mem_Address = base+i, wrapping modulo 2^ADDR_W.
- Lane mapping:
  - Little-endian: the byte at base+i maps to lane i (bits 8i+7:8i).
  - Big-endian: the byte at base+i maps to lane Len-i.
- Store: Mem_WR=1, Mem_Data = the mapped lane of the latched WData.
- Load: Mem_WR=0; on the clock edge, MemOut is captured into the mapped lane of the assembly register.
- When i=Len, go to DONE.
- DONE:
  - Done=1.
  - On a load, RData = assembly result. Lanes Len+1..WORD_BYTES-1 are zero, or copies of bit 8*(Len+1)-1 when SignExt=1.
  - SignExt is ignored on a store.
  - RData is registered and appears in the Done cycle.
  - Start=1 in DONE: latch the new request and go straight to XFER. Otherwise go to IDLE.
- Start while Busy=1 is ignored; the request is not queued.
- Memory outputs outside XFER: Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0.

## Timing
- Reset values:
  - Outputs: Busy=0, Done=0, RData=0, NextAddr=0, Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0.
  - Internal: state=IDLE.
- Start accepted at edge k:
  - XFER runs cycles k+1..k+Len+1.
  - Done is high in cycle k+Len+2.
- Throughput: back-to-back requests take Len+2 cycles each, with no idle gap.
- Memory write commits at the edge that ends each XFER cycle.
- Reset low mid-transfer:
  - Next cycle: IDLE, Mem_CS=1, no Done.
  - Bytes already written remain in memory; remaining bytes are not written.
  - RData is cleared.
- Reset has priority over Start.

## Structure
- Package word_mem_seq_pkg:
  - state encoding (IDLE/XFER/DONE);
  - OP_LOAD/OP_STORE constants;
  - lane-index function for the endian mapping.
- Sub-module byte_lane_mux:
  - WORD_BYTES-parameterised;
  - extracts a lane for store and inserts a lane for load.
  - It generalises the current fixed 4-way MuxC.

## Test plan
- Little-endian store, WORD_BYTES=4: Addr=0x0010, WData=0xA1B2C3D4, Len=3 → writes D4@0x0010, C3@0x0011, B2@0x0012, A1@0x0013 on consecutive cycles; Done at k+5; NextAddr=0x0014.
- Big-endian signed load, BIG_ENDIAN=1: mem[0x20]=0x80, mem[0x21]=0x05, Len=1, SignExt=1 → RData=0xFFFF8005. Same with SignExt=0 → RData=0x00008005.
- Address wrap: store with Addr=0xFFFE, Len=3 → addresses FFFE, FFFF, 0000, 0001; NextAddr=0x0002.
- Back-to-back and ignored Start:
  - Start with a new request in the Done cycle → its first byte goes out in the next cycle.
  - Start toggled during Busy → no extra transfer occurs and the latched Op is unchanged.
- Reset mid-transfer: Reset low after the 2nd byte of a 4-byte store at 0x0010 → next cycle Mem_CS=1, Busy=0, no Done pulse; 0x0012 and 0x0013 unchanged.
- WORD_BYTES=8 little-endian load, Len=7: memory holds bytes 0x01..0x08 at 0x0100..0x0107 → RData=0x0807060504030201.

Source files
------------

// File: rtl/word_memory_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// word_mem_seq_pkg
// Shared definitions for the multi-byte memory transfer engine:
//   - state_t      : sequencer state encoding (IDLE / XFER / DONE)
//   - OP_LOAD/STORE: transfer direction encoding of the Op input
//   - lane_index() : maps a byte index within a transfer to a word lane,
//                    honouring little- or big-endian lane order
// ---------------------------------------------------------------------------
package word_mem_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    // Byte at base+idx lands in lane idx (little-endian) or len-idx (big-endian).
    function automatic int unsigned lane_index(input int unsigned idx,
                                               input int unsigned len,
                                               input bit          big_endian);
        int unsigned lane;
        if (big_endian) begin
            lane = len - idx;
        end else begin
            lane = idx;
        end
        return lane;
    endfunction

endpackage

// File: rtl/word_memory_sequencer_byte_lane_mux.sv
// ---------------------------------------------------------------------------
// byte_lane_mux
// WORD_BYTES-wide byte lane selector used by the transfer engine.
//   Extract path : i_src_word, i_src_lane -> o_src_byte (store byte source)
//   Insert path  : i_dst_word with lane i_dst_lane replaced by i_dst_byte
//                  -> o_dst_word (load assembly)
// Purely combinational.
// ---------------------------------------------------------------------------
module byte_lane_mux #(
    parameter  int WORD_BYTES = 4,
    localparam int LEN_W      = $clog2(WORD_BYTES),
    localparam int DW         = 8 * WORD_BYTES
) (
    input  logic [DW-1:0]    i_src_word,
    input  logic [LEN_W-1:0] i_src_lane,
    output logic [7:0]       o_src_byte,
    input  logic [DW-1:0]    i_dst_word,
    input  logic [LEN_W-1:0] i_dst_lane,
    input  logic [7:0]       i_dst_byte,
    output logic [DW-1:0]    o_dst_word
);

    // Lane extract for stores and lane insert for loads.
    always_comb begin
        o_src_byte = i_src_word[{i_src_lane, 3'b000} +: 8];
        o_dst_word = i_dst_word;
        for (int l = 0; l < WORD_BYTES; l++) begin
            o_dst_word[8*l +: 8] = (i_dst_lane == LEN_W'(l)) ? i_dst_byte
                                                             : i_dst_word[8*l +: 8];
        end
    end

endmodule

// File: rtl/word_memory_sequencer.sv
// ---------------------------------------------------------------------------
// word_memory_sequencer
// Moves 1..WORD_BYTES bytes between a word and a byte-wide memory, one byte
// per cycle at consecutive (wrapping) addresses.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_start, i_op, i_len  request, 0=load/1=store, byte count minus one
//   i_addr, i_wdata       base address, store word
//   i_sign_ext            load: sign-fill lanes above Len
//   o_mem_address/o_mem_data/o_mem_wr/o_mem_cs, i_mem_out   memory port
//   o_busy, o_done        in transfer, one-cycle completion pulse
//   o_rdata, o_next_addr  load result, Addr+Len+1
// All outputs are registered.
// ---------------------------------------------------------------------------
module word_memory_sequencer
    import word_mem_seq_pkg::*;
#(
    parameter  int WORD_BYTES = 4,
    parameter  int ADDR_W     = 16,
    parameter  int BIG_ENDIAN = 0,
    localparam int LEN_W      = $clog2(WORD_BYTES),
    localparam int DW         = 8 * WORD_BYTES
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DW-1:0]     i_wdata,
    input  logic              i_sign_ext,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [7:0]        o_mem_data,
    output logic              o_mem_wr,
    output logic              o_mem_cs,
    input  logic [7:0]        i_mem_out,
    output logic              o_busy,
    output logic              o_done,
    output logic [DW-1:0]     o_rdata,
    output logic [ADDR_W-1:0] o_next_addr
);

    state_t              r_state;
    logic                r_op;
    logic                r_sign_ext;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [DW-1:0]       r_wdata;
    logic [DW-1:0]       r_asm;
    logic [DW-1:0]       r_rdata;
    logic [ADDR_W-1:0]   r_mem_address;
    logic [ADDR_W-1:0]   r_next_addr;
    logic [7:0]          r_mem_data;
    logic                r_mem_wr;
    logic                r_mem_cs;
    logic                r_busy;
    logic                r_done;

    logic [DW-1:0]       w_src_word;
    logic [LEN_W-1:0]    w_src_idx;
    logic [LEN_W-1:0]    w_src_len;
    logic [LEN_W-1:0]    w_src_lane;
    logic [LEN_W-1:0]    w_cur_lane;
    logic [7:0]          w_src_byte;
    logic [DW-1:0]       w_asm_ins;
    logic [DW-1:0]       w_asm_final;
    logic [7:0]          w_fill;

    // Store byte for the NEXT cycle: first byte of a new request, or the following byte.
    always_comb begin
        if (r_state == S_XFER) begin
            w_src_word = r_wdata;
            w_src_idx  = r_idx + LEN_W'(1);
            w_src_len  = r_len;
        end else begin
            w_src_word = i_wdata;
            w_src_idx  = {LEN_W{1'b0}};
            w_src_len  = i_len;
        end
        w_src_lane = LEN_W'(lane_index(32'(w_src_idx), 32'(w_src_len), BIG_ENDIAN != 0));
        w_cur_lane = LEN_W'(lane_index(32'(r_idx), 32'(r_len), BIG_ENDIAN != 0));
    end

    byte_lane_mux #(
        .WORD_BYTES (WORD_BYTES)
    ) u_lane_mux (
        .i_src_word (w_src_word),
        .i_src_lane (w_src_lane),
        .o_src_byte (w_src_byte),
        .i_dst_word (r_asm),
        .i_dst_lane (w_cur_lane),
        .i_dst_byte (i_mem_out),
        .o_dst_word (w_asm_ins)
    );

    // Final load word: lanes above Len take zero or the sign of lane Len's top bit.
    always_comb begin
        w_fill      = (r_sign_ext && w_asm_ins[{r_len, 3'b111}]) ? 8'hFF : 8'h00;
        w_asm_final = w_asm_ins;
        for (int l = 0; l < WORD_BYTES; l++) begin
            w_asm_final[8*l +: 8] = (LEN_W'(l) > r_len) ? w_fill : w_asm_ins[8*l +: 8];
        end
    end

    // Sequencer FSM with registered memory port, status and result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_op          <= OP_LOAD;
            r_sign_ext    <= 1'b0;
            r_len         <= {LEN_W{1'b0}};
            r_idx         <= {LEN_W{1'b0}};
            r_wdata       <= {DW{1'b0}};
            r_asm         <= {DW{1'b0}};
            r_rdata       <= {DW{1'b0}};
            r_mem_address <= {ADDR_W{1'b0}};
            r_next_addr   <= {ADDR_W{1'b0}};
            r_mem_data    <= 8'h00;
            r_mem_wr      <= 1'b0;
            r_mem_cs      <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts a new request exactly like IDLE, giving gap-free chaining.
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state       <= S_XFER;
                        r_busy        <= 1'b1;
                        r_op          <= i_op;
                        r_len         <= i_len;
                        r_wdata       <= i_wdata;
                        r_sign_ext    <= i_sign_ext;
                        r_idx         <= {LEN_W{1'b0}};
                        r_asm         <= {DW{1'b0}};
                        r_mem_cs      <= 1'b0;
                        r_mem_wr      <= (i_op == OP_STORE);
                        r_mem_address <= i_addr;
                        r_mem_data    <= (i_op == OP_STORE) ? w_src_byte : 8'h00;
                    end else begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_mem_cs      <= 1'b1;
                        r_mem_wr      <= 1'b0;
                        r_mem_address <= {ADDR_W{1'b0}};
                        r_mem_data    <= 8'h00;
                    end
                end
                S_XFER: begin
                    r_asm <= w_asm_ins;
                    if (r_idx == r_len) begin
                        r_state       <= S_DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_next_addr   <= r_mem_address + ADDR_W'(1);
                        r_mem_cs      <= 1'b1;
                        r_mem_wr      <= 1'b0;
                        r_mem_address <= {ADDR_W{1'b0}};
                        r_mem_data    <= 8'h00;
                        if (r_op == OP_LOAD) begin
                            r_rdata <= w_asm_final;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                    end else begin
                        r_idx         <= r_idx + LEN_W'(1);
                        r_mem_address <= r_mem_address + ADDR_W'(1);
                        r_mem_data    <= (r_op == OP_STORE) ? w_src_byte : 8'h00;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                    r_mem_cs      <= 1'b1;
                    r_mem_wr      <= 1'b0;
                    r_mem_address <= {ADDR_W{1'b0}};
                    r_mem_data    <= 8'h00;
                end
            endcase
        end
    end

    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_wr      = r_mem_wr;
    assign o_mem_cs      = r_mem_cs;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_rdata       = r_rdata;
    assign o_next_addr   = r_next_addr;

endmodule

// File: tb/tb_word_memory_sequencer.sv
// ---------------------------------------------------------------------------
// tb_word_memory_sequencer
// Three sequencer instances: [0] 4-byte little-endian, [1] 4-byte big-endian,
// [2] 8-byte little-endian, each with its own byte memory. Expected results
// come from a shadow memory and a byte-list model of each transfer.
// ---------------------------------------------------------------------------
module tb_word_memory_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start [3];
    logic        op    [3];
    logic [2:0]  len   [3];
    logic [15:0] addr  [3];
    logic [63:0] wdata [3];
    logic        sext  [3];

    wire  [15:0] mem_addr  [3];
    wire  [7:0]  mem_data  [3];
    wire         mem_wr    [3];
    wire         mem_cs    [3];
    wire         busy      [3];
    wire         done      [3];
    wire  [63:0] rdata     [3];
    wire  [15:0] next_addr [3];

    logic [7:0]  mem     [3][65536];
    logic [7:0]  exp_mem [3][65536];
    logic [63:0] last_rd [3];

    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WB = (g == 2) ? 8 : 4;
        localparam int LW = $clog2(WB);
        wire [8*WB-1:0] rd_w;
        word_memory_sequencer #(
            .WORD_BYTES (WB),
            .ADDR_W     (16),
            .BIG_ENDIAN ((g == 1) ? 1 : 0)
        ) u_dut (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_start       (start[g]),
            .i_op          (op[g]),
            .i_len         (len[g][LW-1:0]),
            .i_addr        (addr[g]),
            .i_wdata       (wdata[g][8*WB-1:0]),
            .i_sign_ext    (sext[g]),
            .o_mem_address (mem_addr[g]),
            .o_mem_data    (mem_data[g]),
            .o_mem_wr      (mem_wr[g]),
            .o_mem_cs      (mem_cs[g]),
            .i_mem_out     (mem[g][mem_addr[g]]),
            .o_busy        (busy[g]),
            .o_done        (done[g]),
            .o_rdata       (rd_w),
            .o_next_addr   (next_addr[g])
        );
        assign rdata[g] = 64'(rd_w);
    end

    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (!mem_cs[g] && mem_wr[g]) mem[g][mem_addr[g]] <= mem_data[g];
        end
    end

    // One transfer on instance s, checked cycle by cycle. Called at a negedge,
    // returns at the negedge of the Done cycle with Start low.
    task automatic run_xfer(input int s, input bit op_i, input int len_i,
                            input logic [15:0] a_i, input logic [63:0] wd_i,
                            input bit se_i, input bit poke);
        int          wb;
        bit          big;
        int          lane;
        int          nbits;
        logic [63:0] exp_rd;
        logic [63:0] fullm;
        logic [15:0] ea;
        logic [7:0]  eb;
        wb    = (s == 2) ? 8 : 4;
        big   = (s == 1);
        fullm = (wb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        exp_rd = 64'd0;
        for (int i = 0; i <= len_i; i++) begin
            ea = a_i + 16'(i);
            if (big) exp_rd = (exp_rd << 8) | 64'(exp_mem[s][ea]);
            else     exp_rd = exp_rd | (64'(exp_mem[s][ea]) << (8 * i));
        end
        nbits = 8 * (len_i + 1);
        if (se_i && exp_rd[nbits-1]) exp_rd = (exp_rd | ~((64'd1 << nbits) - 64'd1)) & fullm;
        if (op_i) exp_rd = last_rd[s];
        else      last_rd[s] = exp_rd;

        start[s] = 1'b1; op[s] = op_i; len[s] = 3'(len_i);
        addr[s] = a_i; wdata[s] = wd_i; sext[s] = se_i;
        @(posedge clk);
        @(negedge clk);
        start[s] = 1'b0;
        for (int i = 0; i <= len_i; i++) begin
            ea   = a_i + 16'(i);
            lane = big ? (len_i - i) : i;
            eb   = 8'(wd_i >> (8 * lane));
            n_checks++;
            if (mem_cs[s] !== 1'b0 || mem_addr[s] !== ea || mem_wr[s] !== op_i ||
                busy[s] !== 1'b1 || done[s] !== 1'b0 || (op_i && mem_data[s] !== eb))
                $display("FAIL xfer_cycle[%0d] byte %0d: cs=%b addr=%h wr=%b data=%h busy=%b done=%b, required cs=0 addr=%h wr=%b data=%h busy=1 done=0",
                         s, i, mem_cs[s], mem_addr[s], mem_wr[s], mem_data[s], busy[s], done[s], ea, op_i, eb);
            else n_pass++;
            if (op_i) exp_mem[s][ea] = eb;
            if (poke) begin
                start[s] = ~start[s]; op[s] = ~op_i; addr[s] = 16'($urandom);
            end
            @(negedge clk);
        end
        start[s] = 1'b0;
        n_checks++;
        if (done[s] !== 1'b1 || busy[s] !== 1'b0 || mem_cs[s] !== 1'b1 ||
            next_addr[s] !== 16'(a_i + 16'(len_i) + 16'd1) || rdata[s] !== exp_rd)
            $display("FAIL xfer_done[%0d]: done=%b busy=%b cs=%b next=%h rdata=%h, required done=1 busy=0 cs=1 next=%h rdata=%h",
                     s, done[s], busy[s], mem_cs[s], next_addr[s], rdata[s],
                     16'(a_i + 16'(len_i) + 16'd1), exp_rd);
        else n_pass++;
        if (op_i) begin
            for (int i = 0; i <= len_i; i++) begin
                ea = a_i + 16'(i);
                n_checks++;
                if (mem[s][ea] !== exp_mem[s][ea])
                    $display("FAIL store_mem[%0d] @%h: got %h, required %h", s, ea, mem[s][ea], exp_mem[s][ea]);
                else n_pass++;
            end
        end
    endtask

    task automatic check_idle(input int s, input string name);
        n_checks++;
        if (mem_cs[s] !== 1'b1 || busy[s] !== 1'b0 || done[s] !== 1'b0 || mem_wr[s] !== 1'b0 || mem_addr[s] !== 16'h0000)
            $display("FAIL %s[%0d]: cs=%b busy=%b done=%b wr=%b addr=%h, required cs=1 busy=0 done=0 wr=0 addr=0000",
                     name, s, mem_cs[s], busy[s], done[s], mem_wr[s], mem_addr[s]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0; op[g] = 1'b0; len[g] = 3'd0; addr[g] = 16'h0;
            wdata[g] = 64'h0; sext[g] = 1'b0; last_rd[g] = 64'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            n_checks++;
            if (busy[g] !== 1'b0 || done[g] !== 1'b0 || rdata[g] !== 64'h0 || next_addr[g] !== 16'h0 ||
                mem_cs[g] !== 1'b1 || mem_wr[g] !== 1'b0 || mem_addr[g] !== 16'h0 || mem_data[g] !== 8'h0)
                $display("FAIL reset_state[%0d]: busy=%b done=%b rdata=%h next=%h cs=%b wr=%b addr=%h data=%h, required 0 0 0 0 1 0 0 0",
                         g, busy[g], done[g], rdata[g], next_addr[g], mem_cs[g], mem_wr[g], mem_addr[g], mem_data[g]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_le_store();
        logic [7:0] e [4];
        e = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        run_xfer(0, 1'b1, 3, 16'h0010, 64'hA1B2C3D4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[0][16'h0010 + 16'(i)] !== e[i])
                $display("FAIL le_store_byte @%h: got %h, required %h", 16'h0010 + 16'(i), mem[0][16'h0010 + 16'(i)], e[i]);
            else n_pass++;
        end
        n_checks++;
        if (next_addr[0] !== 16'h0014) $display("FAIL le_store_next: got %h, required 0014", next_addr[0]);
        else n_pass++;
    endtask

    task automatic test_be_load();
        run_xfer(1, 1'b1, 1, 16'h0020, 64'h8005, 1'b0, 1'b0);
        run_xfer(1, 1'b0, 1, 16'h0020, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if (rdata[1] !== 64'hFFFF8005) $display("FAIL be_load_signed: got %h, required FFFF8005", rdata[1]);
        else n_pass++;
        run_xfer(1, 1'b0, 1, 16'h0020, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if (rdata[1] !== 64'h00008005) $display("FAIL be_load_unsigned: got %h, required 00008005", rdata[1]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_xfer(0, 1'b1, 3, 16'hFFFE, 64'(32'h5566_7788), 1'b0, 1'b0);
        n_checks++;
        if (next_addr[0] !== 16'h0002) $display("FAIL wrap_next: got %h, required 0002", next_addr[0]);
        else n_pass++;
        run_xfer(0, 1'b0, 3, 16'hFFFE, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if (rdata[0] !== 64'h5566_7788) $display("FAIL wrap_load: got %h, required 55667788", rdata[0]);
        else n_pass++;
    endtask

    task automatic test_w8_load();
        run_xfer(2, 1'b1, 7, 16'h0100, 64'h0807060504030201, 1'b0, 1'b0);
        run_xfer(2, 1'b0, 7, 16'h0100, 64'h0, 1'b1, 1'b0);
        n_checks++;
        if (rdata[2] !== 64'h0807060504030201) $display("FAIL w8_load: got %h, required 0807060504030201", rdata[2]);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        run_xfer(0, 1'b0, 3, 16'h0010, 64'h0, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(0, "ignored_start_load");
        run_xfer(0, 1'b1, 2, 16'h0040, 64'h00C0FFEE, 1'b0, 1'b1);
        @(negedge clk);
        check_idle(0, "ignored_start_store");
    endtask

    task automatic test_back_to_back();
        run_xfer(0, 1'b1, 1, 16'h0030, 64'h9A7E, 1'b0, 1'b0);
        run_xfer(0, 1'b0, 1, 16'h0030, 64'h0, 1'b1, 1'b0);
        run_xfer(0, 1'b1, 0, 16'h0031, 64'h11, 1'b0, 1'b0);
        run_xfer(0, 1'b0, 1, 16'h0030, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_idle(0, "b2b_tail");
    endtask

    task automatic test_reset_mid();
        start[0] = 1'b1; op[0] = 1'b1; len[0] = 3'd3; addr[0] = 16'h0010;
        wdata[0] = 64'h11223344; sext[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle(0, "reset_mid_next");
        n_checks++;
        if (rdata[0] !== 64'h0) $display("FAIL reset_mid_rdata: got %h, required 0", rdata[0]);
        else n_pass++;
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) last_rd[g] = 64'h0;
        exp_mem[0][16'h0010] = 8'h44;
        exp_mem[0][16'h0011] = 8'h33;
        repeat (3) begin
            @(negedge clk);
            check_idle(0, "reset_mid_after");
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[0][16'h0010 + 16'(i)] !== exp_mem[0][16'h0010 + 16'(i)])
                $display("FAIL reset_mid_mem @%h: got %h, required %h", 16'h0010 + 16'(i),
                         mem[0][16'h0010 + 16'(i)], exp_mem[0][16'h0010 + 16'(i)]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int wb;
        int l;
        for (int s = 0; s < 3; s++) begin
            wb = (s == 2) ? 8 : 4;
            for (int j = 0; j < 32 / wb; j++)
                run_xfer(s, 1'b1, wb - 1, 16'hFFF0 + 16'(j * wb), {$urandom, $urandom}, 1'b0, 1'b0);
            for (int n = 0; n < 25; n++) begin
                l = $urandom_range(0, wb - 1);
                run_xfer(s, 1'($urandom), l, 16'hFFF0 + 16'($urandom_range(0, 31 - l)),
                         {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 7) == 0));
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_le_store();
        test_be_load();
        test_wrap();
        test_w8_load();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
